// File: rtl/dsp_pkg.sv
// ---------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the FB42 DSP MAC sequencer.
//   - DSP mode encodings (half / mixed / full; 2'b11 is not a legal mode)
//   - sequencer FSM state encoding
//   - helper that classifies a job descriptor as illegal
// ---------------------------------------------------------------------------
package dsp_pkg;

    localparam logic [1:0] MODE_HALF  = 2'b00;
    localparam logic [1:0] MODE_MIXED = 2'b01;
    localparam logic [1:0] MODE_FULL  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A job is rejected (answered with an error, no DSP traffic) when its
    // mode is not one of the three DSP modes or it carries no terms.
    function automatic logic job_is_illegal(input logic [1:0] mode,
                                            input logic       len_zero);
        logic mode_ok;
        mode_ok = (mode == MODE_HALF) || (mode == MODE_MIXED) || (mode == MODE_FULL);
        return !mode_ok || len_zero;
    endfunction

endpackage

// File: rtl/dsp_pending_counter.sv
// ---------------------------------------------------------------------------
// dsp_pending_counter
// Up/down counter of DSP operations in flight.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear (new job), highest priority
//   inc         one start issued this cycle
//   dec         one result pulse returned this cycle
//   count       current number of outstanding operations
//   zero_pulse  high in the cycle whose update takes count from 1 to 0
// A simultaneous inc and dec leaves the count unchanged. A dec with nothing
// outstanding is dropped so the counter never wraps.
// ---------------------------------------------------------------------------
module dsp_pending_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero_pulse
);

    logic dec_ok;

    assign dec_ok     = dec && (count != '0);
    assign zero_pulse = dec_ok && !inc && (count == W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec_ok) begin
            count <= count + 1'b1;
        end else if (dec_ok && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// ---------------------------------------------------------------------------
// dsp_mac_sequencer
// Initiator-side driver for the FB42 DSP MAC slice. Takes a job descriptor
// and a stream of operand pairs, issues one DSP start per cycle while the job
// is active, counts returning compare_res pulses and hands the final
// accumulator value out on a result port.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   job_*                           job descriptor (valid/ready)
//   op_valid/op_ready/op_a/op_b     operand stream (valid/ready)
//   dsp_*  (outputs)                registered DSP controls and operands
//   dsp_compare_res, dsp_out        DSP result pulse and value
//   res_valid/res_ready/res_data/res_err   result port (valid/ready)
//   dbg_state                       current FSM state (dsp_pkg::state_t)
//
// Handshakes: every channel transfers on a rising clk edge where valid and
// ready are both high. A producer holds valid and its payload stable until
// that edge; ready may depend combinationally on valid (op_ready does).
// job_ready is only raised in IDLE with no result outstanding; res_valid is
// held with stable res_data/res_err until res_ready is seen.
// ---------------------------------------------------------------------------
import dsp_pkg::*;

module dsp_mac_sequencer #(
    parameter int WIDTH         = 16,
    parameter int SHIFT_BITS    = 2,
    parameter int PIPELINE_BITS = 3,
    parameter int LEN_BITS      = 8,
    parameter int TIMEOUT       = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [1:0]               job_mode,
    input  logic [LEN_BITS-1:0]      job_len,
    input  logic [2*WIDTH-1:0]       job_bias,
    input  logic                     job_shift_en,
    input  logic                     job_shift_dir,
    input  logic [SHIFT_BITS-1:0]    job_shift_amt,
    input  logic [PIPELINE_BITS-1:0] job_pipe,

    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [WIDTH-1:0]         op_a,
    input  logic [WIDTH-1:0]         op_b,

    output logic                     dsp_start,
    output logic                     dsp_mac,
    output logic                     dsp_shift_enable,
    output logic                     dsp_shift_dir,
    output logic [1:0]               dsp_mode,
    output logic [SHIFT_BITS-1:0]    dsp_shift_amount,
    output logic [PIPELINE_BITS-1:0] dsp_pipe_stages,
    output logic [WIDTH-1:0]         dsp_aa,
    output logic [WIDTH-1:0]         dsp_bb,
    output logic [2*WIDTH-1:0]       dsp_cc,
    input  logic                     dsp_compare_res,
    input  logic [2*WIDTH-1:0]       dsp_out,

    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2*WIDTH-1:0]       res_data,
    output logic                     res_err,

    output logic [1:0]               dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t              state, state_nx;
    logic [LEN_BITS-1:0] remaining;
    logic [LEN_BITS:0]   pending;
    logic [WD_W-1:0]     wd_cnt;
    logic                err;

    logic                accept;
    logic                illegal;
    logic                op_fire;
    logic                bubble;
    logic                finish_ok;
    logic                finish_to;
    logic                pend_inc;
    logic                pend_dec;
    logic                pend_zero;

    assign dbg_state = state;
    assign illegal   = job_is_illegal(job_mode, job_len == '0);

    // Every ISSUE cycle registers a start. Pulses outside ISSUE/DRAIN belong
    // to nothing we are waiting for and are ignored.
    assign pend_inc = (state == ISSUE);
    assign pend_dec = dsp_compare_res && ((state == ISSUE) || (state == DRAIN));

    dsp_pending_counter #(
        .W (LEN_BITS + 1)
    ) u_pending (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (accept),
        .inc        (pend_inc),
        .dec        (pend_dec),
        .count      (pending),
        .zero_pulse (pend_zero)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and handshake strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        job_ready = 1'b0;
        op_ready  = 1'b0;
        accept    = 1'b0;
        op_fire   = 1'b0;
        bubble    = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        case (state)
            IDLE: begin
                if (job_valid && !res_valid) begin
                    job_ready = 1'b1;
                    accept    = 1'b1;
                    state_nx  = illegal ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                op_ready = op_valid;
                op_fire  = op_valid;
                bubble   = !op_valid;
                if (op_valid && (remaining == LEN_BITS'(1))) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // The last start is counted on the DRAIN entry edge, so an
                // empty counter here can only mean everything has returned.
                if (pend_zero || (pending == '0)) begin
                    finish_ok = 1'b1;
                    state_nx  = DONE;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    finish_to = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: DSP-facing registers, job bookkeeping, result port
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_start        <= 1'b0;
            dsp_mac          <= 1'b0;
            dsp_shift_enable <= 1'b0;
            dsp_shift_dir    <= 1'b0;
            dsp_mode         <= '0;
            dsp_shift_amount <= '0;
            dsp_pipe_stages  <= '0;
            dsp_aa           <= '0;
            dsp_bb           <= '0;
            dsp_cc           <= '0;
            res_valid        <= 1'b0;
            res_data         <= '0;
            res_err          <= 1'b0;
            remaining        <= '0;
            wd_cnt           <= '0;
            err              <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // mac low between jobs forces the DSP to reload cc on
                    // the first start of the next job.
                    dsp_start <= 1'b0;
                    dsp_mac   <= 1'b0;
                    dsp_aa    <= '0;
                    dsp_bb    <= '0;
                    if (accept) begin
                        remaining <= job_len;
                        wd_cnt    <= '0;
                        err       <= 1'b0;
                        if (illegal) begin
                            res_valid <= 1'b1;
                            res_data  <= '0;
                            res_err   <= 1'b1;
                        end else begin
                            dsp_mode         <= job_mode;
                            dsp_cc           <= job_bias;
                            dsp_shift_enable <= job_shift_en;
                            dsp_shift_dir    <= job_shift_dir;
                            dsp_shift_amount <= job_shift_amt;
                            dsp_pipe_stages  <= job_pipe;
                        end
                    end
                end
                ISSUE: begin
                    // A bubble still starts the DSP with a zero product, which
                    // leaves the sum untouched but would re-apply a shift.
                    dsp_start <= 1'b1;
                    dsp_mac   <= 1'b1;
                    wd_cnt    <= '0;
                    dsp_aa    <= op_fire ? op_a : '0;
                    dsp_bb    <= op_fire ? op_b : '0;
                    if (op_fire) begin
                        remaining <= remaining - 1'b1;
                    end
                    if (bubble && dsp_shift_enable) begin
                        err <= 1'b1;
                    end
                end
                DRAIN: begin
                    dsp_start <= 1'b0;
                    dsp_mac   <= 1'b0;
                    dsp_aa    <= '0;
                    dsp_bb    <= '0;
                    wd_cnt    <= wd_cnt + 1'b1;
                    if (finish_ok) begin
                        res_valid <= 1'b1;
                        res_data  <= dsp_out;
                        res_err   <= err;
                    end else if (finish_to) begin
                        res_valid <= 1'b1;
                        res_data  <= dsp_out;
                        res_err   <= 1'b1;
                    end
                end
                DONE: begin
                    dsp_start <= 1'b0;
                    dsp_mac   <= 1'b0;
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                    end
                end
                default: begin
                    dsp_start <= 1'b0;
                    dsp_mac   <= 1'b0;
                end
            endcase
        end
    end

endmodule
